// File: rtl/snake_pkg.sv
// Shared playfield constants and spawner state encoding for the snake game.
// Contents:
//   PF_* localparams : cell size, playfield origin, legal grid and screen size
//   LFSR_TAPS        : Galois feedback mask for the 16-bit game LFSR
//   spawn_state_e    : food spawner FSM states
//   lfsr_next()      : one Galois shift step (right shift, taps XORed on carry-out)
package snake_pkg;

  localparam int PF_CELL     = 20;
  localparam int PF_X_MIN    = 20;
  localparam int PF_Y_MIN    = 20;
  localparam int PF_COLS     = 30;
  localparam int PF_ROWS     = 22;
  localparam int PF_SCREEN_W = 640;
  localparam int PF_SCREEN_H = 480;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    PROBE,
    WAIT
  } spawn_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/food_spawner_lfsr16.sv
// 16-bit free-running Galois LFSR, reusable wherever the game needs randomness.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, loads seed
//   seed : reset / recovery value (nonzero)
//   out  : current LFSR state
module lfsr16
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // An all-zero state is a lock-up point for the LFSR; recover from the seed.
  always_comb begin
    state_d = (state_q == '0) ? seed : lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= seed;
    else     state_q <= state_d;
  end

  assign out = state_q;

endmodule

// File: rtl/food_spawner.sv
// Food spawner: on req, draws a random grid cell from an LFSR, probes the
// snake body checker for occupancy, and places food on the first free cell.
// After MAX_TRIES occupied random draws it scans linearly from the last
// candidate; if the whole grid is occupied it pulses full.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req                 : one-cycle spawn request (honoured only when idle)
//   food_x/food_y       : placed food cell origin in pixels
//   food_valid          : food_x/food_y hold a placed food
//   busy                : spawn in progress
//   full                : one-cycle pulse, no free cell exists
//   probe_x/probe_y     : candidate cell origin for the occupancy check
//   probe_valid         : one-cycle probe strobe
//   probe_hit           : candidate occupied, valid the cycle after probe_valid
module food_spawner
  import snake_pkg::*;
#(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter int          CELL      = PF_CELL,
  parameter int          X_MIN     = PF_X_MIN,
  parameter int          Y_MIN     = PF_Y_MIN,
  parameter int          COLS      = PF_COLS,
  parameter int          ROWS      = PF_ROWS,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 15,
  parameter int          RST_CX    = 14,
  parameter int          RST_CY    = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic [X_W-1:0] food_x,
  output logic [Y_W-1:0] food_y,
  output logic           food_valid,
  output logic           busy,
  output logic           full,
  output logic [X_W-1:0] probe_x,
  output logic [Y_W-1:0] probe_y,
  output logic           probe_valid,
  input  logic           probe_hit
);

  localparam int CXW   = $clog2(COLS);
  localparam int CYW   = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;
  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int SW    = $clog2(CELLS + 1);

  localparam logic [CXW:0]    COLS_W     = (CXW + 1)'(COLS);
  localparam logic [CYW:0]    ROWS_W     = (CYW + 1)'(ROWS);
  localparam logic [CXW-1:0]  CX_LAST    = CXW'(COLS - 1);
  localparam logic [CYW-1:0]  CY_LAST    = CYW'(ROWS - 1);
  localparam logic [TW-1:0]   TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [SW-1:0]   SCAN_LAST  = SW'(CELLS - 1);
  localparam logic [X_W-1:0]  RST_X      = X_W'(X_MIN + RST_CX * CELL);
  localparam logic [Y_W-1:0]  RST_Y      = Y_W'(Y_MIN + RST_CY * CELL);

  function automatic logic [X_W-1:0] cell_px(input logic [CXW-1:0] c);
    return X_W'(X_MIN) + X_W'(c) * X_W'(CELL);
  endfunction

  function automatic logic [Y_W-1:0] cell_py(input logic [CYW-1:0] c);
    return Y_W'(Y_MIN) + Y_W'(c) * Y_W'(CELL);
  endfunction

  logic [15:0]    lfsr;
  logic [CXW-1:0] rnd_cx;
  logic [CYW-1:0] rnd_cy;
  logic           rnd_ok;
  logic           lfsr_unused;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .out  (lfsr)
  );

  assign rnd_cx      = lfsr[CXW-1:0];
  assign rnd_cy      = lfsr[CXW+CYW-1:CXW];
  assign rnd_ok      = ({1'b0, rnd_cx} < COLS_W) && ({1'b0, rnd_cy} < ROWS_W);
  assign lfsr_unused = ^lfsr[15:CXW+CYW];

  spawn_state_e   state_q, state_d;
  logic [CXW-1:0] cand_cx_q, cand_cx_d;
  logic [CYW-1:0] cand_cy_q, cand_cy_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
  logic           scan_q, scan_d;
  logic [X_W-1:0] food_x_q, food_x_d;
  logic [Y_W-1:0] food_y_q, food_y_d;
  logic           food_valid_q, food_valid_d;
  logic           busy_q, busy_d;
  logic           full_q, full_d;
  logic [X_W-1:0] probe_x_q, probe_x_d;
  logic [Y_W-1:0] probe_y_q, probe_y_d;
  logic           probe_valid_q, probe_valid_d;

  // Next cell in raster order, wrapping at the end of a row and of the grid.
  logic [CXW-1:0] adv_cx;
  logic [CYW-1:0] adv_cy;

  always_comb begin
    adv_cx = cand_cx_q + 1'b1;
    adv_cy = cand_cy_q;
    if (cand_cx_q == CX_LAST) begin
      adv_cx = '0;
      adv_cy = (cand_cy_q == CY_LAST) ? '0 : cand_cy_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_cx_d    = cand_cx_q;
    cand_cy_d    = cand_cy_q;
    tries_d      = tries_q;
    scan_cnt_d   = scan_cnt_q;
    scan_d       = scan_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    busy_d       = busy_q;
    full_d       = 1'b0;
    probe_x_d    = probe_x_q;
    probe_y_d    = probe_y_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          food_valid_d = 1'b0;
          busy_d       = 1'b1;
          tries_d      = '0;
          scan_d       = 1'b0;
          scan_cnt_d   = '0;
          state_d      = GEN;
        end
      end
      GEN: begin
        // Out-of-range draws just wait for the next LFSR value.
        if (rnd_ok) begin
          cand_cx_d = rnd_cx;
          cand_cy_d = rnd_cy;
          probe_x_d = cell_px(rnd_cx);
          probe_y_d = cell_py(rnd_cy);
          state_d   = PROBE;
        end
      end
      PROBE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!probe_hit) begin
          food_x_d     = probe_x_q;
          food_y_d     = probe_y_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (!scan_q) begin
          tries_d = tries_q + 1'b1;
          if (tries_q == TRIES_LAST) begin
            scan_d     = 1'b1;
            scan_cnt_d = '0;
            cand_cx_d  = adv_cx;
            cand_cy_d  = adv_cy;
            probe_x_d  = cell_px(adv_cx);
            probe_y_d  = cell_py(adv_cy);
            state_d    = PROBE;
          end else begin
            state_d = GEN;
          end
        end else begin
          if (scan_cnt_q == SCAN_LAST) begin
            full_d  = 1'b1;
            busy_d  = 1'b0;
            scan_d  = 1'b0;
            state_d = IDLE;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            cand_cx_d  = adv_cx;
            cand_cy_d  = adv_cy;
            probe_x_d  = cell_px(adv_cx);
            probe_y_d  = cell_py(adv_cy);
            state_d    = PROBE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // PROBE is never held, so the strobe is exactly one cycle wide.
    probe_valid_d = (state_d == PROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_cx_q     <= '0;
      cand_cy_q     <= '0;
      tries_q       <= '0;
      scan_cnt_q    <= '0;
      scan_q        <= 1'b0;
      food_x_q      <= RST_X;
      food_y_q      <= RST_Y;
      food_valid_q  <= 1'b1;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
      probe_x_q     <= '0;
      probe_y_q     <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_cx_q     <= cand_cx_d;
      cand_cy_q     <= cand_cy_d;
      tries_q       <= tries_d;
      scan_cnt_q    <= scan_cnt_d;
      scan_q        <= scan_d;
      food_x_q      <= food_x_d;
      food_y_q      <= food_y_d;
      food_valid_q  <= food_valid_d;
      busy_q        <= busy_d;
      full_q        <= full_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign food_x      = food_x_q;
  assign food_y      = food_y_q;
  assign food_valid  = food_valid_q;
  assign busy        = busy_q;
  assign full        = full_q;
  assign probe_x     = probe_x_q;
  assign probe_y     = probe_y_q;
  assign probe_valid = probe_valid_q;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner with a behavioural snake-body responder.
module tb_food_spawner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [9:0] food_x;
  logic [8:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       full;
  logic [9:0] probe_x;
  logic [8:0] probe_y;
  logic       probe_valid;
  logic       probe_hit = 1'b0;

  food_spawner #(
    .X_W       (10),
    .Y_W       (9),
    .SEED      (16'hACE1),
    .MAX_TRIES (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .food_x      (food_x),
    .food_y      (food_y),
    .food_valid  (food_valid),
    .busy        (busy),
    .full        (full),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .probe_valid (probe_valid),
    .probe_hit   (probe_hit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Responder modes: 0 all free, 1 all occupied, 2 first hit_n probes
  // occupied, 3 everything occupied except cell (600,440).
  int mode       = 0;
  int hit_n      = 0;
  int cyc        = 0;
  int strobes    = 0;
  int strobe_cyc = 0;
  int fulls      = 0;
  int full_cyc   = -1;
  int fall_cyc   = -2;
  logic busy_prev = 1'b0;
  int pxs [0:1023];
  int pys [0:1023];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (full) begin
      fulls++;
      full_cyc = cyc;
    end
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
    if (probe_valid) begin
      if (strobes < 1024) begin
        pxs[strobes] = int'(probe_x);
        pys[strobes] = int'(probe_y);
      end
      strobes++;
      strobe_cyc = cyc;
      case (mode)
        0:       probe_hit = 1'b0;
        1:       probe_hit = 1'b1;
        2:       probe_hit = (strobes <= hit_n);
        default: probe_hit = !(probe_x == 10'd600 && probe_y == 9'd440);
      endcase
    end
  end

  function automatic void adv(input int x, input int y, output int nx, output int ny);
    if (x == 600) begin
      nx = 20;
      ny = (y == 440) ? 20 : y + 20;
    end else begin
      nx = x + 20;
      ny = y;
    end
  endfunction

  // Pulse req for one cycle and wait (bounded) for busy to drop.
  task automatic do_spawn(input int budget, output int fv_cyc, output logic timed_out);
    int n;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = busy;
    fv_cyc    = cyc;
  endtask

  initial begin
    int   fv;
    logic to;
    int   grid_bad, lat_bad, place_bad, timeouts, step_bad, wraps;
    int   ex, ey, s0, n, last_x, last_y;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_food_x", food_x, 300);
    check("rst_food_y", food_y, 200);
    check("rst_food_valid", food_valid, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_no_probe", strobes, 0);

    // 2: free board, 200 spawns
    mode = 0;
    grid_bad = 0; lat_bad = 0; place_bad = 0; timeouts = 0;
    for (int i = 0; i < 200; i++) begin
      do_spawn(100, fv, to);
      if (to) timeouts++;
      if (!food_valid) place_bad++;
      if (food_x < 20 || food_x > 600 || (int'(food_x) - 20) % 20 != 0) grid_bad++;
      if (food_y < 20 || food_y > 440 || (int'(food_y) - 20) % 20 != 0) grid_bad++;
      if (int'(food_x) != pxs[strobes - 1] || int'(food_y) != pys[strobes - 1]) place_bad++;
      if (fv - strobe_cyc != 2) lat_bad++;
      repeat (5) @(negedge clk);
    end
    check("free_timeouts", timeouts, 0);
    check("free_grid", grid_bad, 0);
    check("free_place", place_bad, 0);
    check("free_latency", lat_bad, 0);
    check("free_strobes", strobes, 200);

    // 3: 15 occupied random probes, then free scan cell
    mode = 2; hit_n = 15; strobes = 0;
    do_spawn(500, fv, to);
    check("t3_timeout", to, 0);
    check("t3_strobes", strobes, 16);
    adv(pxs[14], pys[14], ex, ey);
    check("t3_scan_x", pxs[15], ex);
    check("t3_scan_y", pys[15], ey);
    check("t3_food_x", food_x, ex);
    check("t3_food_y", food_y, ey);
    check("t3_food_valid", food_valid, 1);
    last_x = ex; last_y = ey;

    // 4: board full
    repeat (3) @(negedge clk);
    mode = 1; strobes = 0; fulls = 0;
    do_spawn(4000, fv, to);
    repeat (2) @(negedge clk);
    check("full_timeout", to, 0);
    check("full_strobes", strobes, 675);
    check("full_pulses", fulls, 1);
    check("full_busy_fall", fall_cyc, full_cyc);
    check("full_food_valid", food_valid, 0);
    check("full_food_x_kept", food_x, last_x);
    check("full_food_y_kept", food_y, last_y);
    step_bad = 0; wraps = 0;
    for (int i = 15; i < 675; i++) begin
      adv(pxs[i - 1], pys[i - 1], ex, ey);
      if (pxs[i] != ex || pys[i] != ey) step_bad++;
      if (pxs[i - 1] == 600 && pys[i - 1] == 440 && pxs[i] == 20 && pys[i] == 20) wraps++;
    end
    check("scan_steps", step_bad, 0);
    check("scan_wrap", wraps, 1);

    // 5: only (600,440) free
    mode = 3; strobes = 0; fulls = 0;
    do_spawn(4000, fv, to);
    check("last_cell_timeout", to, 0);
    check("last_cell_x", food_x, 600);
    check("last_cell_y", food_y, 440);
    check("last_cell_valid", food_valid, 1);
    check("last_cell_no_full", fulls, 0);

    // 6a: req while busy is ignored
    repeat (3) @(negedge clk);
    mode = 0; strobes = 0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("busy_req_strobes", strobes, 1);
    check("busy_req_busy", busy, 0);
    check("busy_req_valid", food_valid, 1);

    // 6b: reset in WAIT with hit pending
    mode = 1; strobes = 0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    n = 0;
    while (!probe_valid && n < 100) begin @(negedge clk); n++; end
    check("abort_probe_seen", probe_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_food_x", food_x, 300);
    check("abort_food_y", food_y, 200);
    check("abort_food_valid", food_valid, 1);
    check("abort_busy", busy, 0);
    s0 = strobes;
    repeat (10) @(negedge clk);
    check("abort_no_probe", strobes, s0);
    check("abort_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
